// File: rtl/and8_rr_arbiter.sv
// Round-robin arbiter that time-shares one 8-bit AND bank among NREQ
// requesters and presents each result on a registered valid/ready channel
// tagged with the index of the requester that produced it.

// Shared datapath: plain 8-bit bitwise AND.
module and8_gate (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   assign y = a & b;

endmodule

// state   | meaning
// --------+------------------------------------------------------------
// S_EMPTY | no result held; out_valid=0; a new grant may be issued
// S_FULL  | result held on out/out_id; out_valid=1; grant only on a pop
module and8_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] in1_bus,
   input  logic [8*NREQ-1:0] in2_bus,
   output logic [NREQ-1:0]   gnt,
   output logic [7:0]        out,
   output logic [IDW-1:0]    out_id,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic           accept;
   logic           grant;
   logic [7:0]     op_a;
   logic [7:0]     op_b;
   logic [7:0]     and_y;

   assign out_valid = (state == S_FULL);
   assign accept    = (state == S_EMPTY) || (out_valid && out_ready);
   assign grant     = accept && gnt_any && !reset;

   // Pick the first requester at or after ptr (wrapping) and steer its operands.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      op_a    = '0;
      op_b    = '0;
      for (int d = 0; d < NREQ; d++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req[k] && (((int'(ptr) + d) % NREQ) == k)) begin
               gnt_any = 1'b1;
               gnt_idx = IDW'(k);
               op_a    = in1_bus[8*k +: 8];
               op_b    = in2_bus[8*k +: 8];
            end
         end
      end
   end

   // One-hot grant, suppressed when the output slot cannot take a result.
   always_comb begin
      gnt = '0;
      for (int k = 0; k < NREQ; k++) begin
         gnt[k] = grant && (gnt_idx == IDW'(k));
      end
   end

   and8_gate u_and8 (
      .a (op_a),
      .b (op_b),
      .y (and_y)
   );

   // Next state and pointer; a pop with a simultaneous grant stays FULL.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      if (grant) begin
         state_nxt = S_FULL;
         ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (accept) begin
         state_nxt = S_EMPTY;
      end
   end

   // State, pointer and result registers; result only loads on a grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_EMPTY;
         ptr    <= '0;
         out    <= 8'h00;
         out_id <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         if (grant) begin
            out    <= and_y;
            out_id <= gnt_idx;
         end
      end
   end

endmodule
